// File: rtl/rv32_pkg.sv
// Shared RV32 types and constants for the iterative multiply/divide unit.
package rv32_pkg;

    localparam int XLEN         = 32;
    localparam int MULDIV_ITERS = 32;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    // The upper funct3 bit separates the divide group from the multiply group.
    function automatic logic is_div_op(muldiv_op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_unit_if;
    import rv32_pkg::*;

    logic            start;
    logic            flush;
    muldiv_op_t      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, flush, funct3, op_a, op_b, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, flush, funct3, op_a, op_b, rd_in,
        output busy, done, result, rd_out
    );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: turns signed operands into magnitudes
// and re-applies the result sign after the unsigned iteration.
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] fixed
);

    assign fixed = negate ? -value : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle over 32 cycles, with divide-by-zero/overflow answered at once.
module muldiv_unit
    import rv32_pkg::*;
(
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);

    localparam logic [4:0]      LAST_ITER = 5'(MULDIV_ITERS - 1);
    localparam logic [XLEN-1:0] ALL_ONES  = '1;
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t   state, state_next;
    muldiv_op_t      op;
    logic [4:0]      count;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic            neg_res;
    logic [XLEN-1:0] result_q;
    logic [4:0]      rd_out_q;
    logic            busy;
    logic            done;
    logic            accept;

    logic            signed_a, signed_b;
    logic            sign_a, sign_b;
    logic            start_neg, start_div, special;
    logic [XLEN-1:0] special_value;
    logic [XLEN-1:0] mag_a, mag_b;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     partial_rem;
    logic              rem_ge;
    logic [XLEN-1:0]   hi_next, lo_next;
    logic [2*XLEN-1:0] fix_in, fix_out;
    logic [XLEN-1:0]   final_result;

    assign accept = bus.start && !bus.flush;

    // Operand signedness, result sign and the RISC-V no-trap corner cases.
    always_comb begin
        signed_a      = bus.funct3 inside {MUL, MULH, MULHSU, DIV, REM};
        signed_b      = bus.funct3 inside {MUL, MULH, DIV, REM};
        sign_a        = signed_a & bus.op_a[XLEN-1];
        sign_b        = signed_b & bus.op_b[XLEN-1];
        start_div     = is_div_op(bus.funct3);
        start_neg     = (bus.funct3 inside {REM, REMU}) ? sign_a : (sign_a ^ sign_b);
        special       = 1'b0;
        special_value = '0;
        if (start_div) begin
            if (bus.op_b == '0) begin
                special       = 1'b1;
                special_value = (bus.funct3 inside {DIV, DIVU}) ? ALL_ONES : bus.op_a;
            end else if (signed_b && bus.op_a == INT_MIN && bus.op_b == ALL_ONES) begin
                special       = 1'b1;
                special_value = (bus.funct3 == DIV) ? INT_MIN : '0;
            end
        end
    end

    muldiv_sign_fix #(.WIDTH(XLEN)) fix_a (
        .value (bus.op_a),
        .negate(sign_a),
        .fixed (mag_a)
    );

    muldiv_sign_fix #(.WIDTH(XLEN)) fix_b (
        .value (bus.op_b),
        .negate(sign_b),
        .fixed (mag_b)
    );

    // Multiply keeps {acc_hi, acc_lo} as product/multiplier pair shifting right;
    // divide shifts the dividend out of acc_lo into a 33-bit partial remainder.
    always_comb begin
        mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        partial_rem = {acc_hi, acc_lo[XLEN-1]};
        rem_ge      = partial_rem >= {1'b0, operand};
        if (is_div_op(op)) begin
            hi_next = rem_ge ? (partial_rem[XLEN-1:0] - operand) : partial_rem[XLEN-1:0];
            lo_next = {acc_lo[XLEN-2:0], rem_ge};
        end else begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
    end

    assign fix_in = is_div_op(op)
                  ? {{XLEN{1'b0}}, ((op inside {REM, REMU}) ? hi_next : lo_next)}
                  : {hi_next, lo_next};

    muldiv_sign_fix #(.WIDTH(2*XLEN)) fix_out_inst (
        .value (fix_in),
        .negate(neg_res),
        .fixed (fix_out)
    );

    assign final_result = (op inside {MULH, MULHSU, MULHU}) ? fix_out[2*XLEN-1:XLEN]
                                                           : fix_out[XLEN-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_next = IDLE;
                end else if (count == LAST_ITER) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                done       = !bus.flush;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Result and rd_out only change on entry to DONE, so a flushed op leaves them intact.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op       <= MUL;
            count    <= '0;
            rd_q     <= '0;
            operand  <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            neg_res  <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op      <= bus.funct3;
                        rd_q    <= bus.rd_in;
                        neg_res <= start_neg;
                        count   <= '0;
                        acc_hi  <= '0;
                        operand <= start_div ? mag_b : mag_a;
                        acc_lo  <= start_div ? mag_a : mag_b;
                        if (special) begin
                            result_q <= special_value;
                            rd_out_q <= bus.rd_in;
                        end
                    end
                end
                CALC: begin
                    if (!bus.flush) begin
                        acc_hi <= hi_next;
                        acc_lo <= lo_next;
                        count  <= count + 5'd1;
                        if (count == LAST_ITER) begin
                            result_q <= final_result;
                            rd_out_q <= rd_q;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

endmodule
